// File: rtl/pred_pkg.sv
// Shared types and defaults for the branch predictor table init sequencer.
// BHT encoding constants give callers names for the init values they drive.
package pred_pkg;
    localparam int DEPTH_DEF     = 256;
    localparam int ADDR_W_DEF    = 8;
    localparam int BTB_W_DEF     = 40;
    localparam int DRAIN_CYC_DEF = 4;

    localparam logic [1:0] BHT_STRONG_NT = 2'b00;
    localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
    localparam logic [1:0] BHT_WEAK_T    = 2'b10;
    localparam logic [1:0] BHT_STRONG_T  = 2'b11;

    typedef enum logic [2:0] {
        ST_PREP,
        ST_SWEEP,
        ST_READY,
        ST_RUN,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/pred_init_ctrl.sv
// Sweeps the BTB/BHT with default values after reset or re-init request and
// only then lets the user run switch through to the PC start enable.
module pred_init_ctrl
    import pred_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,   // must equal $clog2(DEPTH)
    parameter int BTB_W     = BTB_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic              start_switch,
    input  logic [1:0]        bht_default,
    input  logic [BTB_W-1:0]  btb_default,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [1:0]        bht_init,
    output logic [BTB_W-1:0]  btb_init,
    output logic              fetch_en,
    output logic              busy,
    output logic              ready
);
    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(DRAIN_CYC - 1);

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DCNT_W-1:0]  r_dcnt, w_dcnt_nxt;
    logic [1:0]         r_bht;
    logic [BTB_W-1:0]   r_btb;
    logic               w_latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PREP;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_bht   <= '0;
            r_btb   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            if (w_latch) begin
                r_bht <= bht_default;
                r_btb <= btb_default;
            end
        end
    end

    // Counters default to zero so every SWEEP/DRAIN entry starts from 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_dcnt_nxt  = '0;
        w_latch     = 1'b0;
        case (r_state)
            ST_PREP: begin
                w_state_nxt = ST_SWEEP;
                w_latch     = 1'b1;
            end
            ST_SWEEP: begin
                if (init_req) begin
                    w_latch = 1'b1;
                end else if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_latch     = 1'b1;
                end else if (start_switch) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    w_state_nxt = ST_DRAIN;
                end else if (!start_switch) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_DRAIN: begin
                if (r_dcnt == LAST_DRAIN) begin
                    w_state_nxt = ST_SWEEP;
                    w_latch     = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_PREP;
        endcase
    end

    // Outputs decode purely from registered state so reset drops them at once.
    assign tbl_we   = (r_state == ST_SWEEP);
    assign tbl_addr = tbl_we ? r_cnt : '0;
    assign bht_init = tbl_we ? r_bht : '0;
    assign btb_init = tbl_we ? r_btb : '0;
    assign fetch_en = (r_state == ST_RUN);
    assign busy     = (r_state == ST_PREP) || (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign ready    = (r_state == ST_READY) || (r_state == ST_RUN);
endmodule
